// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared FSM encodings and hex segment table for the digit scanner
package scan_pkg;

  typedef enum logic [0:0] {
    STATE_DEAD = 1'b0,
    STATE_ON   = 1'b1
  } state_e;

  localparam logic [7:0] ALL_OFF = 8'hFF;

  // Active-low segments {dp,g,f,e,d,c,b,a}; entry 15 listed first
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational nibble to active-low 7-segment decoder
module hex_to_seg
  import scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/scan_scheduler.sv
// rtl/scan_scheduler.sv - tick-paced 8-digit display scanner with dead-time and per-frame snapshot
module scan_scheduler
  import scan_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DWELL  = 16,
  parameter int DEAD   = 2,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [31:0] numb,
  input  logic [7:0]  digit_mask,
  output logic [7:0]  anodes,
  output logic [7:0]  cathodes,
  output logic [2:0]  digit_sel,
  output logic        frame_start
);

  localparam bit              HAS_DEAD   = (DEAD > 0);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(HAS_DEAD ? DEAD - 1 : 0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [2:0]       SEL_LAST   = 3'(DIGITS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] phase_q;
  logic [2:0]       sel_q;
  logic [31:0]      snap_numb_q;
  logic [7:0]       snap_mask_q;
  logic [7:0]       anodes_q;
  logic [7:0]       cathodes_q;
  logic             frame_start_q;

  logic        dead_done;
  logic        dwell_done;
  logic        wrap;
  logic [2:0]  sel_next;
  logic [2:0]  show_sel;
  logic [31:0] show_numb;
  logic [7:0]  show_mask;
  logic [3:0]  show_nibble;
  logic [7:0]  show_seg;
  logic        show_on;
  logic [7:0]  show_anodes;
  logic [7:0]  show_cathodes;

  always_comb begin
    dead_done  = !HAS_DEAD || (phase_q == DEAD_LAST);
    dwell_done = (phase_q == DWELL_LAST);
    wrap       = (state_q == STATE_ON) && dwell_done && (sel_q == SEL_LAST);
    sel_next   = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
    // The digit about to be lit: current slot leaving DEAD, next slot when ON runs back-to-back
    show_sel   = (state_q == STATE_DEAD) ? sel_q : sel_next;
    // On a wrap the snapshot reloads on this very edge, so decode from the live inputs
    show_numb  = wrap ? numb : snap_numb_q;
    show_mask  = wrap ? digit_mask : snap_mask_q;
    show_nibble = show_numb[{show_sel, 2'b00} +: 4];
    show_on    = show_mask[show_sel];
    show_anodes   = show_on ? ~(8'd1 << show_sel) : ALL_OFF;
    show_cathodes = show_on ? show_seg : ALL_OFF;
  end

  hex_to_seg u_hex_to_seg (
    .nibble_i (show_nibble),
    .seg_o    (show_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= STATE_DEAD;
      phase_q       <= '0;
      sel_q         <= 3'd0;
      anodes_q      <= ALL_OFF;
      cathodes_q    <= ALL_OFF;
      frame_start_q <= 1'b0;
      snap_numb_q   <= numb;
      snap_mask_q   <= digit_mask;
    end else begin
      frame_start_q <= 1'b0;
      if (tick) begin
        case (state_q)
          STATE_DEAD: begin
            if (dead_done) begin
              state_q    <= STATE_ON;
              phase_q    <= '0;
              anodes_q   <= show_anodes;
              cathodes_q <= show_cathodes;
            end else begin
              phase_q <= phase_q + CNT_W'(1);
            end
          end
          STATE_ON: begin
            if (dwell_done) begin
              phase_q       <= '0;
              sel_q         <= sel_next;
              frame_start_q <= wrap;
              if (wrap) begin
                snap_numb_q <= numb;
                snap_mask_q <= digit_mask;
              end
              if (HAS_DEAD) begin
                state_q    <= STATE_DEAD;
                anodes_q   <= ALL_OFF;
                cathodes_q <= ALL_OFF;
              end else begin
                anodes_q   <= show_anodes;
                cathodes_q <= show_cathodes;
              end
            end else begin
              phase_q <= phase_q + CNT_W'(1);
            end
          end
          default: state_q <= STATE_DEAD;
        endcase
      end
    end
  end

  assign anodes      = anodes_q;
  assign cathodes    = cathodes_q;
  assign digit_sel   = sel_q;
  assign frame_start = frame_start_q;

endmodule
